// File: rtl/instr_loader.sv
// instr_loader: writes instruction memory from a length-prefixed,
// little-endian host byte stream and holds the CPU in reset while loading.
//
// Stream: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, each
// word least-significant byte first. When INSTR_LOADER_CHECKSUM_EN is
// defined, one trailing byte carries the XOR of all data bytes.
//
// Parameters:
//   WIDTH      data/address width
//   BASE_ADDR  byte address of word 0 (the PC reset vector)
//   MAX_WORDS  memory capacity in words; words beyond it are consumed, not written
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a load (honoured only in IDLE or DONE)
//   byte_in, byte_valid   stream byte and its valid
//   byte_ready            loader accepts a byte this cycle
//   WE, WA, WD            instruction memory write pulse, byte address, data
//   busy                  load in progress (CPU reset hold)
//   done                  last load completed
//   err                   checksum mismatch (always 0 without the checksum build)
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN

module instr_loader #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(32'hBFC00000),
    parameter int unsigned      MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             WE,
    output logic [WIDTH-1:0] WA,
    output logic [WIDTH-1:0] WD,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    // State entered once all words are written (or immediately when N=0)
    localparam logic [2:0] ST_END = CSUM_EN ? ST_CHECK : ST_DONE;

    logic [2:0]  state_q, state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;      // words still to be written, including the current one
    logic [15:0] widx_q;     // index of the word being assembled
    logic [1:0]  bcnt_q;     // data bytes already received for the current word
    logic [23:0] shift_q;    // first three bytes of the current word
    logic        ready_d, busy_d, we_d;
    logic        xfer, accept_start, in_range, last_byte;

    assign xfer         = byte_valid && byte_ready;
    assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_range     = {16'd0, widx_q} < 32'(MAX_WORDS);
    assign last_byte    = xfer && (state_q == ST_DATA) && (bcnt_q == 2'd3);

    // Next state and next values of the registered handshake/status outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LEN_LO;
            ST_LEN_LO:        if (xfer)  state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (xfer) state_d = ({byte_in, len_lo_q} == 16'd0) ? ST_END : ST_DATA;
            end
            ST_DATA:          if (last_byte) state_d = ST_WRITE;
            ST_WRITE:         state_d = (rem_q == 16'd1) ? ST_END : ST_DATA;
            ST_CHECK:         if (xfer)  state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                  (state_d == ST_DATA)   || (state_d == ST_CHECK);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        we_d    = (state_d == ST_WRITE) && in_range;
    end

    // State, registered outputs and word assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            WE         <= 1'b0;
            done       <= 1'b0;
            WA         <= BASE_ADDR;
            WD         <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            widx_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_ready <= ready_d;
            busy       <= busy_d;
            WE         <= we_d;
            done       <= (state_d == ST_DONE);

            if (accept_start) begin
                widx_q <= '0;
                bcnt_q <= '0;
            end
            if (xfer && (state_q == ST_LEN_LO)) len_lo_q <= byte_in;
            if (xfer && (state_q == ST_LEN_HI)) rem_q    <= {byte_in, len_lo_q};

            if (xfer && (state_q == ST_DATA)) begin
                bcnt_q  <= bcnt_q + 2'd1;
                shift_q <= {byte_in, shift_q[23:8]};
            end
            // Address/data only move for words that are actually written
            if (last_byte && in_range) begin
                WA <= BASE_ADDR + (WIDTH'(widx_q) << 2);
                WD <= WIDTH'({byte_in, shift_q});
            end

            if (state_q == ST_WRITE) begin
                rem_q  <= rem_q - 16'd1;
                widx_q <= widx_q + 16'd1;
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running XOR of data bytes; compared against the trailing checksum byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
            err    <= 1'b0;
        end else if (accept_start) begin
            csum_q <= '0;
            err    <= 1'b0;
        end else begin
            if (xfer && (state_q == ST_DATA))  csum_q <= csum_q ^ byte_in;
            if (xfer && (state_q == ST_CHECK)) err    <= (byte_in != csum_q);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
